// File: rtl/param_sequence_detector.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Reports each match as a one-cycle registered pulse and keeps a saturating match count.
module param_sequence_detector #(
    parameter int            W             = 8,
    parameter int            CNT_W         = 8,
    parameter logic [W-1:0]  RESET_PATTERN = W'(8'b0011_0011),
    parameter int            RESET_LEN     = 6,
    parameter bit            RESET_OVERLAP = 1'b1,
    localparam int           LW            = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             new_bit,
    input  logic             cfg_we,
    input  logic [W-1:0]     cfg_pattern,
    input  logic [LW-1:0]    cfg_len,
    input  logic             cfg_overlap,
    input  logic             clear,
    output logic             detected,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [LW-1:0]    LEN_MAX = LW'(W);

    logic [W-1:0]  pattern;
    logic [W-1:0]  history;
    logic [W-1:0]  hist_next;
    logic [W-1:0]  mask;
    logic [LW-1:0] len;
    logic [LW-1:0] len_clamped;
    logic [LW-1:0] fill;
    logic [LW-1:0] fill_next;
    logic          overlap;
    logic          accept;
    logic          match;

    // A bit arriving on a clear or reconfigure edge is dropped.
    assign accept      = in_valid && !cfg_we && !clear;
    assign hist_next   = {history[W-2:0], new_bit};
    assign fill_next   = (fill >= len) ? len : fill + LW'(1);
    assign len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    always_comb begin
        mask = '0;
        for (int i = 0; i < W; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign match = accept
                && (len != '0)
                && (((hist_next ^ pattern) & mask) == '0)
                && (fill_next >= len);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern <= RESET_PATTERN;
            len     <= LW'(RESET_LEN);
            overlap <= RESET_OVERLAP;
        end else if (cfg_we) begin
            pattern <= cfg_pattern;
            len     <= len_clamped;
            overlap <= cfg_overlap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            history <= '0;
            fill    <= '0;
        end else if (clear || cfg_we) begin
            history <= '0;
            fill    <= '0;
        end else if (accept) begin
            history <= hist_next;
            // Non-overlap mode restarts the fill so the next match needs fresh bits.
            fill    <= (match && !overlap) ? '0 : fill_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            detected    <= 1'b0;
            match_count <= '0;
        end else begin
            detected <= match;
            if (clear) begin
                match_count <= '0;
            end else if (match && (match_count != CNT_MAX)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/param_sequence_detector.md
PARAM_SEQUENCE_DETECTOR -- requirements
Module: param_sequence_detector

Interface
REQ-001 Parameter W, default 8, maximum pattern length in bits (W >= 2).
REQ-002 Parameter CNT_W, default 8, width of the match counter.
REQ-003 Parameter RESET_PATTERN, default 8'b0011_0011 (W bits), pattern loaded at reset ("110011" in the low 6 bits).
REQ-004 Parameter RESET_LEN, default 6, pattern length loaded at reset (1..W).
REQ-005 Parameter RESET_OVERLAP, default 1, overlap mode loaded at reset.
REQ-006 clk  input  1  clock; all state changes on the rising edge except reset.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 in_valid  input  1  new_bit is accepted on a rising edge only when this is 1.
REQ-009 new_bit  input  1  serial input bit; the earliest-received bit of a match compares against the MSB of the active pattern.
REQ-010 cfg_we  input  1  loads cfg_pattern, cfg_len and cfg_overlap on the rising edge.
REQ-011 cfg_pattern  input  W  new pattern, right-aligned; only bits [len-1:0] are significant.
REQ-012 cfg_len  input  $clog2(W+1)  new pattern length.
REQ-013 cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
REQ-014 clear  input  1  synchronous clear of match_count and history.
REQ-015 detected  output  1  registered one-cycle match pulse.
REQ-016 match_count  output  CNT_W  saturating count of matches.

Function
REQ-017 Keep a W-bit history shift register; on each accepted bit, shift left with new_bit entering at bit 0. Hold the register when in_valid = 0.
REQ-018 Keep a fill counter of accepted bits since the last reset, clear, cfg_we or non-overlap match, saturating at len.
REQ-019 A match occurs on an accepted bit when both hold:
  - the updated history bits [len-1:0] equal pattern[len-1:0];
  - the updated fill count is >= len.
REQ-020 On a match, assert detected for exactly the one cycle after that rising edge; otherwise detected = 0. Latency is 1 cycle.
REQ-021 With overlap = 1, history and fill are kept after a match, so back-to-back or overlapping matches are each reported.
REQ-022 With overlap = 0, a match resets the fill count to 0; the next match requires len fresh accepted bits.
REQ-023 On a match, match_count increments by 1 and saturates at 2^CNT_W-1 (no wrap).
REQ-024 With len = 0, detection is disabled: detected stays 0 and match_count holds. A cfg_len value greater than W is stored as W.
REQ-025 On a cfg_we edge:
  - load the pattern, len and overlap registers;
  - zero the history and fill;
  - ignore any new_bit on the same edge (no match possible on that edge);
  - leave match_count unchanged.
REQ-026 On a clear edge, zero match_count, history and fill, and drive detected to 0 next cycle. Any in_valid bit on the same edge is discarded.
REQ-027 clear and cfg_we on the same edge: both effects apply.
REQ-028 A gap in in_valid does not break a partial match; matching is over accepted bits only.

Reset
REQ-029 While rst = 0, immediately and regardless of clk:
  - detected = 0, match_count = 0, history = 0, fill = 0;
  - pattern = RESET_PATTERN, len = RESET_LEN, overlap = RESET_OVERLAP.
REQ-030 Reset asserted mid-stream discards any partial match. The first match after release requires len new accepted bits.

Verification
REQ-031 Defaults, in_valid = 1, stream 0011_0101_1001_1001_1010_1000 (left bit first) -> detected high the cycle after bits 12 and 16 (0-indexed) are accepted; match_count = 2.
REQ-032 Load pattern 1010, len 4, overlap 1, then stream 10101010 -> 3 pulses (after bits 3, 5, 7). With overlap 0, the same stream -> 2 pulses (after bits 3, 7).
REQ-033 Default pattern with in_valid = 0 for 3 cycles between every bit of 110011 -> exactly 1 pulse, 1 cycle after the final accepted bit.
REQ-034 CNT_W = 2, pattern 1, len 1, 5 accepted 1-bits -> match_count = 3 after the third match and stays 3. clear then returns it to 0.
REQ-035 Default pattern, feed 11001, then cfg_we (same pattern) or an async rst pulse, then feed 1 -> no pulse; match_count unchanged (cfg_we) or 0 (rst).
REQ-036 cfg_len = W+3 with an all-ones pattern -> len stored as W; W ones give the first pulse, and with overlap 1 each further one gives another pulse.
